// File: rtl/adder_result_checker.sv
// adder_result_checker
// Self-test consumer for the adder result stream. Expected sums are queued
// in a small FIFO by the stimulus side; every adder result beat pops one
// entry and compares it. The block ends in a sticky PASS or FAIL state and
// keeps the cause, the first mismatching pair and the number of matches.
// A cycle watchdog fails the run if no verdict arrives in time.
module adder_result_checker #(
   parameter int BITS       = 16,
   parameter int DEPTH      = 8,
   parameter int NUM_CHECKS = 4,
   parameter int TIMEOUT    = 400
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            exp_valid,
   input  logic [BITS-1:0] exp_data,
   output logic            exp_ready,
   input  logic            valid_out,
   input  logic [BITS-1:0] o,
   output logic            done,
   output logic            pass,
   output logic            fail,
   output logic [1:0]      err_code,
   output logic [BITS-1:0] mismatch_exp,
   output logic [BITS-1:0] mismatch_act,
   output logic [15:0]     check_count
);

   // One extra pointer bit distinguishes full from empty.
   localparam int AW = $clog2(DEPTH);
   // The watchdog only has to reach TIMEOUT-1.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(TIMEOUT - 1);
   localparam logic [15:0]   CHK_GOAL  = 16'(NUM_CHECKS);

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISMATCH = 2'd1;
   localparam logic [1:0] ERR_UNDERFLW = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_PASS = 2'd1,
      S_FAIL = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wptr_q, wptr_d;
   logic [AW:0]     rptr_q, rptr_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [1:0]      err_q, err_d;
   logic [BITS-1:0] mexp_q, mexp_d;
   logic [BITS-1:0] mact_q, mact_d;
   logic [15:0]     cnt_q, cnt_d;

   logic [BITS-1:0] mem_q [DEPTH];

   logic            empty;
   logic            full;
   logic            push;
   logic [BITS-1:0] head;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   // Depends only on registered state, so it reads 1 while reset is held.
   assign exp_ready = (state_q == S_RUN) && !full;
   assign push      = exp_valid && exp_ready;
   assign head      = mem_q[rptr_q[AW-1:0]];

   assign pass         = (state_q == S_PASS);
   assign fail         = (state_q == S_FAIL);
   assign done         = pass | fail;
   assign err_code     = err_q;
   assign mismatch_exp = mexp_q;
   assign mismatch_act = mact_q;
   assign check_count  = cnt_q;

   // FIFO storage; contents are don't-care once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= exp_data;
   end

   // State, pointer, watchdog and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cyc_q   <= '0;
         err_q   <= ERR_NONE;
         mexp_q  <= '0;
         mact_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
         mexp_q  <= mexp_d;
         mact_q  <= mact_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: push, pop/compare, then watchdog as the lowest priority.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cyc_d   = cyc_q;
      err_d   = err_q;
      mexp_d  = mexp_q;
      mact_d  = mact_q;
      cnt_d   = cnt_q;

      if (state_q == S_RUN) begin
         cyc_d = (cyc_q == CYC_LAST) ? cyc_q : cyc_q + 1'b1;

         // exp_ready was taken before the pop, so a full FIFO never pushes here.
         if (push) wptr_d = wptr_q + 1'b1;

         if (valid_out) begin
            if (empty) begin
               // A same-cycle push is not bypassed to the comparator.
               state_d = S_FAIL;
               err_d   = ERR_UNDERFLW;
            end else begin
               rptr_d = rptr_q + 1'b1;
               if (head == o) begin
                  if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                  if (cnt_q + 16'd1 == CHK_GOAL) state_d = S_PASS;
               end else begin
                  state_d = S_FAIL;
                  err_d   = ERR_MISMATCH;
                  mexp_d  = head;
                  mact_d  = o;
               end
            end
         end

         if (state_d == S_RUN && cyc_q == CYC_LAST) begin
            state_d = S_FAIL;
            err_d   = ERR_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker
// Drives two checker instances (default, and one needing 20 matches so the
// read pointer can wrap) from the same stimulus and compares both against a
// queue-based reference model every cycle.
module tb_adder_result_checker;

   localparam int BITS  = 16;
   localparam int DEPTH = 8;
   int nc [2] = '{4, 20};
   int to [2] = '{400, 2000};

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            exp_valid = 1'b0;
   logic [BITS-1:0] exp_data = '0;
   logic            valid_out = 1'b0;
   logic [BITS-1:0] o = '0;

   logic            rdy  [2];
   logic            done [2];
   logic            pass [2];
   logic            fail [2];
   logic [1:0]      err  [2];
   logic [BITS-1:0] mexp [2];
   logic [BITS-1:0] mact [2];
   logic [15:0]     cnt  [2];

   int ntests = 0;
   int nfail  = 0;

   // reference model
   logic [BITS-1:0] mq [2][$];
   bit              mp [2];
   bit              mf [2];
   int              merr [2];
   logic [BITS-1:0] mme [2];
   logic [BITS-1:0] mma [2];
   int              mcnt [2];
   int              mcyc [2];

   always #5 clk = ~clk;

   adder_result_checker #(.BITS(BITS), .DEPTH(DEPTH), .NUM_CHECKS(4), .TIMEOUT(400)) u_dut (
      .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(rdy[0]), .valid_out(valid_out), .o(o), .done(done[0]),
      .pass(pass[0]), .fail(fail[0]), .err_code(err[0]), .mismatch_exp(mexp[0]),
      .mismatch_act(mact[0]), .check_count(cnt[0]));

   adder_result_checker #(.BITS(BITS), .DEPTH(DEPTH), .NUM_CHECKS(20), .TIMEOUT(2000)) u_wrap (
      .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(rdy[1]), .valid_out(valid_out), .o(o), .done(done[1]),
      .pass(pass[1]), .fail(fail[1]), .err_code(err[1]), .mismatch_exp(mexp[1]),
      .mismatch_act(mact[1]), .check_count(cnt[1]));

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[%0d] observed=%h expected=%h at %0t", tag, i, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         mp[i] = 0; mf[i] = 0; merr[i] = 0; mme[i] = '0; mma[i] = '0;
         mcnt[i] = 0; mcyc[i] = 0;
      end
   endtask

   function automatic bit m_ready(input int i);
      return !(mp[i] || mf[i]) && (mq[i].size() < DEPTH);
   endfunction

   // Applies the sampled inputs of one rising edge to the model.
   task automatic model_edge();
      bit acc, dec;
      logic [BITS-1:0] h;
      for (int i = 0; i < 2; i++) begin
         if (!(mp[i] || mf[i])) begin
            acc = exp_valid && (mq[i].size() < DEPTH);
            dec = 0;
            if (valid_out) begin
               if (mq[i].size() == 0) begin
                  mf[i] = 1; merr[i] = 2; dec = 1;
               end else begin
                  h = mq[i].pop_front();
                  if (h == o) begin
                     mcnt[i]++;
                     if (mcnt[i] == nc[i]) begin mp[i] = 1; dec = 1; end
                  end else begin
                     mf[i] = 1; merr[i] = 1; mme[i] = h; mma[i] = o; dec = 1;
                  end
               end
            end
            if (acc) mq[i].push_back(exp_data);
            if (!dec && mcyc[i] == to[i] - 1) begin mf[i] = 1; merr[i] = 3; end
            mcyc[i]++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, ".rdy"},  i, 32'(rdy[i]),  32'(m_ready(i)));
         chk({tag, ".done"}, i, 32'(done[i]), 32'(mp[i] | mf[i]));
         chk({tag, ".pass"}, i, 32'(pass[i]), 32'(mp[i]));
         chk({tag, ".fail"}, i, 32'(fail[i]), 32'(mf[i]));
         chk({tag, ".err"},  i, 32'(err[i]),  32'(merr[i]));
         chk({tag, ".mexp"}, i, 32'(mexp[i]), 32'(mme[i]));
         chk({tag, ".mact"}, i, 32'(mact[i]), 32'(mma[i]));
         chk({tag, ".cnt"},  i, 32'(cnt[i]),  32'(mcnt[i]));
      end
   endtask

   // One clock: drive at negedge, check ready, clock, check outputs.
   task automatic step(input string tag, input bit ev, input logic [BITS-1:0] ed,
                       input bit vo, input logic [BITS-1:0] ov);
      exp_valid = ev; exp_data = ed; valid_out = vo; o = ov;
      #1;
      for (int i = 0; i < 2; i++) chk({tag, ".rdy_pre"}, i, 32'(rdy[i]), 32'(m_ready(i)));
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1; exp_valid = 0; valid_out = 0; exp_data = '0; o = '0;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      #1;
      check_all(tag);
      reset = 1'b0;
      @(negedge clk);
      // the edge after release was idle in both DUT and model
      model_edge();
      check_all({tag, ".rel"});
   endtask

   task automatic push(input string tag, input logic [BITS-1:0] d);
      step(tag, 1, d, 0, '0);
   endtask

   task automatic res(input string tag, input logic [BITS-1:0] d);
      step(tag, 0, '0, 1, d);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) step(tag, 0, '0, 0, '0);
   endtask

   logic [BITS-1:0] pv [4] = '{16'ha2c3, 16'h4fb3, 16'had73, 16'he299};

   initial begin
      logic [BITS-1:0] ov;
      bit ev, vo;

      // pass
      do_reset("rst0");
      for (int k = 0; k < 4; k++) push("pass_push", pv[k]);
      for (int k = 0; k < 4; k++) res("pass_res", pv[k]);
      chk("pass_flag", 0, 32'(pass[0]), 32'd1);
      chk("pass_cnt", 0, 32'(cnt[0]), 32'd4);
      idle("pass_hold", 3);

      // mismatch, later beats ignored
      do_reset("rst1");
      push("mm_push", 16'ha2c3);
      res("mm_res", 16'ha2c4);
      chk("mm_err", 0, 32'(err[0]), 32'd1);
      chk("mm_act", 0, 32'(mact[0]), 32'ha2c4);
      push("mm_frozen", 16'h1111);
      res("mm_ignored", 16'h1111);

      // underflow with a simultaneous push
      do_reset("rst2");
      step("uf", 1, 16'h1234, 1, 16'h1234);
      chk("uf_err", 0, 32'(err[0]), 32'd2);
      chk("uf_cnt", 0, 32'(cnt[0]), 32'd0);

      // full, drop, wrap
      do_reset("rst3");
      for (int k = 0; k < 9; k++) push("full_push", 16'(k));
      chk("full_rdy", 0, 32'(rdy[0]), 32'd0);
      step("full_pop_push", 1, 16'h0099, 1, 16'h0000);
      for (int k = 1; k < 8; k++) res("full_res", 16'(k));
      push("wrap_push", 16'd9);
      push("wrap_push", 16'd10);
      res("wrap_res", 16'd9);
      res("wrap_res", 16'd10);
      chk("wrap_cnt", 1, 32'(cnt[1]), 32'd10);

      // timeout
      do_reset("rst4");
      idle("to_idle", 398);
      chk("to_not_yet", 0, 32'(fail[0]), 32'd0);
      idle("to_edge", 1);
      chk("to_err", 0, 32'(err[0]), 32'd3);

      // last match on the watchdog cycle wins
      do_reset("rst5");
      for (int k = 0; k < 4; k++) push("tp_push", pv[k]);
      idle("tp_idle", 391);
      for (int k = 0; k < 4; k++) res("tp_res", pv[k]);
      chk("tp_pass", 0, 32'(pass[0]), 32'd1);

      // reset mid-run, then a fresh pass
      do_reset("rst6");
      for (int k = 0; k < 4; k++) push("mr_push", pv[k]);
      res("mr_res", pv[0]);
      res("mr_res", pv[1]);
      do_reset("mr_rst");
      for (int k = 0; k < 4; k++) push("mr2_push", pv[3-k]);
      for (int k = 0; k < 4; k++) res("mr2_res", pv[3-k]);
      chk("mr2_pass", 0, 32'(pass[0]), 32'd1);

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         do_reset("rnd_rst");
         for (int k = 0; k < 60; k++) begin
            ev = ($urandom_range(1, 0) == 1);
            vo = ($urandom_range(2, 0) == 0);
            ov = 16'($urandom);
            if (mq[1].size() > 0 && $urandom_range(15, 0) != 0) ov = mq[1][0];
            step("rnd", ev, 16'($urandom), vo, ov);
         end
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "bench timeout");
   end

endmodule
